uart_rx_ctrl: RTL and testbench

- Frame controller for the UART receive path.
- Detects the start bit and times each bit with an edge counter.
- Drives the sampler and the 8-bit LSB-first deserializer, then checks the start, parity and stop bits.
- Reports a one-cycle data_valid when a clean frame has been fully assembled in the deserializer.

---
 rtl/uart_rx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start detect, bit timing, parity/stop checks).
// Optional saturating error counter on port err_cnt when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               par_err,
  input  logic               sampled_bit,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               deser_en,
  output logic               par_chk_en,
  output logic               data_valid,
  output logic               par_error,
  output logic               stp_error
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [PRESC_W-1:0] presc_q, presc_d, presc_in;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               samp_en_q, samp_en_d;
  logic               deser_q, deser_d;
  logic               par_chk_q, par_chk_d;
  logic               valid_q, valid_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               last_edge, pre_last_edge;

  // Even ratio only, with a floor of 8 so the sampler window always fits in a bit.
  always_comb begin
    presc_in = Prescale & ~PRESC_W'(1);
    if (presc_in < PRESC_W'(8)) presc_in = PRESC_W'(8);
  end

  assign last_edge     = (edge_q == presc_q - PRESC_W'(1));
  assign pre_last_edge = (edge_q == presc_q - PRESC_W'(2));

  always_comb begin
    state_d   = state_q;
    edge_d    = (state_q == S_IDLE) ? '0 : (last_edge ? '0 : edge_q + PRESC_W'(1));
    bit_d     = bit_q;
    presc_d   = presc_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    deser_d   = 1'b0;
    par_chk_d = 1'b0;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (!RX_IN) begin
          state_d   = S_START;
          presc_d   = presc_in;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      S_START: begin
        if (last_edge) begin
          state_d = sampled_bit ? S_IDLE : S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        // Strobes are registered one edge early so they sit on the bit's last edge.
        if (pre_last_edge) deser_d = 1'b1;
        if (last_edge) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (pre_last_edge) par_chk_d = 1'b1;
        if (last_edge) begin
          par_err_d = par_err;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (last_edge) begin
          stp_err_d = ~sampled_bit;
          valid_d   = ~par_err_q & sampled_bit;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // DONE is edge 0 of a back-to-back start bit, so the edge counter keeps running.
        if (!RX_IN) begin
          state_d   = S_START;
          presc_d   = presc_in;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) edge_d = '0;
    samp_en_d = (state_d inside {S_START, S_DATA, S_PARITY, S_STOP});
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      presc_q   <= PRESC_W'(8);
      samp_en_q <= 1'b0;
      deser_q   <= 1'b0;
      par_chk_q <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      presc_q   <= presc_d;
      samp_en_q <= samp_en_d;
      deser_q   <= deser_d;
      par_chk_q <= par_chk_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  // data_valid is a one-cycle pulse with no back-pressure: the consumer must take the
  // deserializer byte in that cycle; it stays stable until the next frame's first shift.
  assign dat_samp_en = samp_en_q;
  assign edge_cnt    = edge_q;
  assign deser_en    = deser_q;
  assign par_chk_en  = par_chk_q;
  assign data_valid  = valid_q;
  assign par_error   = par_err_q;
  assign stp_error   = stp_err_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_evt;

  assign err_evt = (state_q == S_START && last_edge && sampled_bit) ||
                   (state_q == S_DONE && (par_err_q || stp_err_q));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: line/sampler driver, deserializer model and data_valid scoreboard.
// Build with UART_RX_ERR_CNT_EN defined to also check err_cnt.
module tb_uart_rx_ctrl;
  localparam int PW = 6;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          par_err;
  logic          sampled_bit = 1'b1;
  logic          par_force = 1'b0;
  logic          dat_samp_en, deser_en, par_chk_en, data_valid, par_error, stp_error;
  logic [PW-1:0] edge_cnt;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  uart_rx_ctrl #(.DATA_W(8), .PRESC_W(PW)) dut (
    .Clk(Clk), .Rst(Rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .par_err(par_err), .sampled_bit(sampled_bit), .dat_samp_en(dat_samp_en),
    .edge_cnt(edge_cnt), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .data_valid(data_valid), .par_error(par_error), .stp_error(stp_error)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // Clock/reset block
  always #5 Clk = ~Clk;

  // The parity checker reports an error only while strobed, and only when forced to.
  assign par_err = par_chk_en & par_force;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_err = 0;
  int         deser_cnt = 0;
  int         dv_cnt = 0;
  int         par_chk_cnt = 0;
  logic [7:0] deser_sr = 8'h00;
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  int         deser_t_q[$];
  int         dv_t_q[$];

  always @(posedge Clk) cyc++;

  // Scoreboard: external LSB-first deserializer model plus data_valid checking.
  always @(negedge Clk) begin
    logic [7:0] exp_d;
    int         exp_t;
    if (deser_en) begin
      deser_sr = {sampled_bit, deser_sr[7:1]};
      deser_cnt++;
      deser_t_q.push_back(cyc);
    end
    if (par_chk_en) par_chk_cnt++;
    if (data_valid) begin
      dv_cnt++;
      dv_t_q.push_back(cyc);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: data_valid at cycle %0d with byte 0x%02h, none expected", cyc, deser_sr);
      end else begin
        exp_d = exp_q.pop_front();
        exp_t = exp_t_q.pop_front();
        if (deser_sr !== exp_d) begin
          n_err++;
          $display("FAIL sb_data: got 0x%02h expected 0x%02h", deser_sr, exp_d);
        end
        n_chk++;
        if (cyc !== exp_t) begin
          n_err++;
          $display("FAIL sb_latency: data_valid at cycle %0d expected %0d", cyc, exp_t);
        end
      end
    end
  end

  // Driver tasks: every task starts and ends 1ns after a rising edge.
  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p / 2) @(posedge Clk);
    #1 sampled_bit = b;
    repeat (p - p / 2) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic par_on,
                            input logic stop_v, input logic good);
    int t0;
    t0 = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_on) drive_bit(^d, p);
    drive_bit(stop_v, p);
    RX_IN = 1'b1;
    if (good) begin
      exp_q.push_back(d);
      exp_t_q.push_back(t0 + 1 + p * (par_on ? 11 : 10));
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge Clk);
    #1 sampled_bit = 1'b1;
  endtask

  function automatic int gap_errs(input int p);
    int e;
    e = 0;
    for (int i = 1; i < deser_t_q.size(); i++)
      if (deser_t_q[i] - deser_t_q[i-1] != p) e++;
    return e;
  endfunction

  task automatic test_reset();
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_chk++;
    if ({dat_samp_en, edge_cnt, deser_en, par_chk_en, data_valid, par_error, stp_error} !== 12'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {dat_samp_en, edge_cnt, deser_en, par_chk_en, data_valid, par_error, stp_error});
    end
`ifdef UART_RX_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
    Rst = 1'b1;
    idle(6);
    n_chk++;
    if ({dat_samp_en, edge_cnt} !== 7'b0) begin
      n_err++;
      $display("FAIL idle_hold: samp_en/edge_cnt got %b expected 0", {dat_samp_en, edge_cnt});
    end
  endtask

  task automatic test_basic();
    int d0, v0, c0;
    Prescale = 6'd8; PAR_EN = 1'b0;
    d0 = deser_cnt; v0 = dv_cnt; c0 = par_chk_cnt;
    deser_t_q.delete();
    send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1);
    idle(5);
    n_chk++;
    if (deser_cnt - d0 != 8 || gap_errs(8) != 0) begin
      n_err++;
      $display("FAIL basic_deser: got %0d pulses with %0d bad gaps expected 8 pulses 8 apart",
               deser_cnt - d0, gap_errs(8));
    end
    n_chk++;
    if (dv_cnt - v0 != 1) begin n_err++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - v0); end
    n_chk++;
    if (par_chk_cnt - c0 != 0) begin n_err++; $display("FAIL basic_par_chk: got %0d expected 0", par_chk_cnt - c0); end
    n_chk++;
    if ({par_error, stp_error} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_flags: got %b expected 00", {par_error, stp_error});
    end
  endtask

  task automatic test_glitch();
    int d0, v0;
    Prescale = 6'd8; PAR_EN = 1'b0;
    d0 = deser_cnt; v0 = dv_cnt;
    RX_IN = 1'b0;
    repeat (3) @(posedge Clk);
    #1 RX_IN = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    n_chk++;
    if (dat_samp_en !== 1'b1) begin n_err++; $display("FAIL glitch_in_start: samp_en got %b expected 1", dat_samp_en); end
    @(posedge Clk);
    #1;
    n_chk++;
    if ({dat_samp_en, edge_cnt} !== 7'b0) begin
      n_err++;
      $display("FAIL glitch_idle: samp_en/edge_cnt got %b expected 0", {dat_samp_en, edge_cnt});
    end
    idle(10);
    n_chk++;
    if (deser_cnt - d0 != 0 || dv_cnt - v0 != 0) begin
      n_err++;
      $display("FAIL glitch_pulses: deser %0d dv %0d expected 0 0", deser_cnt - d0, dv_cnt - v0);
    end
    exp_err++;
`ifdef UART_RX_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL glitch_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
`endif
  endtask

  task automatic test_parity();
    int v0, c0;
    Prescale = 6'd16; PAR_EN = 1'b1; par_force = 1'b1;
    v0 = dv_cnt; c0 = par_chk_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0);
    idle(20);
    n_chk++;
    if ({par_error, stp_error} !== 2'b10) begin
      n_err++;
      $display("FAIL par_flags: par/stp got %b expected 10", {par_error, stp_error});
    end
    n_chk++;
    if (dv_cnt - v0 != 0 || par_chk_cnt - c0 != 1) begin
      n_err++;
      $display("FAIL par_pulses: dv %0d par_chk %0d expected 0 1", dv_cnt - v0, par_chk_cnt - c0);
    end
    exp_err++;
`ifdef UART_RX_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL par_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
`endif
    par_force = 1'b0;
    send_frame(8'h96, 16, 1'b1, 1'b1, 1'b1);
    idle(5);
    n_chk++;
    if (par_error !== 1'b0) begin n_err++; $display("FAIL par_clear: got %b expected 0", par_error); end
    n_chk++;
    if (dv_cnt - v0 != 1 || par_chk_cnt - c0 != 2) begin
      n_err++;
      $display("FAIL par_good_pulses: dv %0d par_chk %0d expected 1 2", dv_cnt - v0, par_chk_cnt - c0);
    end
    PAR_EN = 1'b0; Prescale = 6'd8;
  endtask

  task automatic test_stop_error();
    int v0;
    Prescale = 6'd8; PAR_EN = 1'b0;
    v0 = dv_cnt;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
    idle(5);
    n_chk++;
    if ({par_error, stp_error} !== 2'b01) begin
      n_err++;
      $display("FAIL stop_flags: par/stp got %b expected 01", {par_error, stp_error});
    end
    n_chk++;
    if (dv_cnt - v0 != 0) begin n_err++; $display("FAIL stop_dv: got %0d expected 0", dv_cnt - v0); end
    exp_err++;
`ifdef UART_RX_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL stop_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
`endif
  endtask

  task automatic test_back_to_back();
    Prescale = 6'd8; PAR_EN = 1'b0;
    dv_t_q.delete();
    send_frame(8'h3C, 8, 1'b0, 1'b1, 1'b1);
    send_frame(8'hC3, 8, 1'b0, 1'b1, 1'b1);
    idle(5);
    n_chk++;
    if (dv_t_q.size() != 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d data_valid pulses expected 2", dv_t_q.size());
    end else if (dv_t_q[1] - dv_t_q[0] != 80) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles expected 80", dv_t_q[1] - dv_t_q[0]);
    end
    n_chk++;
    if (stp_error !== 1'b0) begin n_err++; $display("FAIL b2b_stp_clear: got %b expected 0", stp_error); end
  endtask

  task automatic test_prescale_latch();
    int v0;
    Prescale = 6'd5; PAR_EN = 1'b0;
    v0 = dv_cnt;
    deser_t_q.delete();
    fork
      send_frame(8'h6B, 8, 1'b0, 1'b1, 1'b1);
      begin
        repeat (20) @(posedge Clk);
        #1 Prescale = 6'd40;
      end
    join
    Prescale = 6'd8;
    idle(5);
    n_chk++;
    if (deser_t_q.size() != 8 || gap_errs(8) != 0) begin
      n_err++;
      $display("FAIL presc_deser: got %0d pulses with %0d bad gaps expected 8 pulses 8 apart",
               deser_t_q.size(), gap_errs(8));
    end
    n_chk++;
    if (dv_cnt - v0 != 1) begin n_err++; $display("FAIL presc_dv: got %0d expected 1", dv_cnt - v0); end
  endtask

  task automatic test_reset_abort();
    int d0, v0;
    logic [7:0] d;
    d = 8'hE7;
    Prescale = 6'd8; PAR_EN = 1'b0;
    d0 = deser_cnt; v0 = dv_cnt;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    RX_IN = d[4];
    repeat (2) @(posedge Clk);
    #1;
    n_chk++;
    if (deser_cnt - d0 != 4 || dat_samp_en !== 1'b1) begin
      n_err++;
      $display("FAIL abort_setup: deser %0d samp_en %b expected 4 1", deser_cnt - d0, dat_samp_en);
    end
    Rst = 1'b0;
    #1;
    n_chk++;
    if ({dat_samp_en, edge_cnt, deser_en, par_chk_en, data_valid, par_error, stp_error} !== 12'b0) begin
      n_err++;
      $display("FAIL abort_outputs: got %b expected all zero",
               {dat_samp_en, edge_cnt, deser_en, par_chk_en, data_valid, par_error, stp_error});
    end
    exp_err = 0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    idle(6);
    Prescale = 6'd9;
    send_frame(8'h5A, 8, 1'b0, 1'b1, 1'b1);
    idle(5);
    n_chk++;
    if (dv_cnt - v0 != 1 || {par_error, stp_error} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_recover: dv %0d flags %b expected 1 00", dv_cnt - v0, {par_error, stp_error});
    end
`ifdef UART_RX_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin n_err++; $display("FAIL abort_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_stop_error();
    test_back_to_back();
    test_prescale_latch();
    test_reset_abort();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected frames never reported, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
